bit_serial_alu: RTL and testbench

//   Bit-serial ALU sequencer that feeds the 1-bit cells one bit per clock.
//   - Latches two WIDTH-bit operands and an opcode on start.
//   - Presents (x, y, ci) for one bit per cycle, LSB first, to a 1-bit cell.
//   - Holds the carry in a flop and shifts the cell output into the result register.
//   - Reports completion with a one-cycle done pulse.

---
 rtl/alu_defs.sv | 19 +
 rtl/alu_cell_1b.sv | 32 +++
 rtl/bit_serial_alu.sv | 128 ++++++++++++
 tb/tb_bit_serial_alu.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/alu_defs.sv
// Shared opcode and state encodings for the bit-serial ALU.
package alu_defs;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_NOR = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic is_arith(input logic [1:0] op);
    return !op[1];
  endfunction

endpackage

// File: rtl/alu_cell_1b.sv
// Combinational 1-bit ALU cell: full adder, NOR and OR slices selected by opcode.
module alu_cell_1b
  import alu_defs::*;
(
  input  logic       x,
  input  logic       y,
  input  logic       ci,
  input  logic [1:0] op,
  output logic       out,
  output logic       co
);

  logic add_out;
  logic add_co;

  assign add_out = x ^ y ^ ci;
  assign add_co  = (x & y) | (ci & (x ^ y));

  always_comb begin
    out = 1'b0;
    co  = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        out = add_out;
        co  = add_co;
      end
      OP_NOR:  out = ~(x | y);
      default: out = x | y;
    endcase
  end

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU sequencer, LSB first, one bit per clock through alu_cell_1b.
// Optional overflow output enabled by defining BIT_SERIAL_ALU_OVF_EN.
module bit_serial_alu
  import alu_defs::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
`ifdef BIT_SERIAL_ALU_OVF_EN
  output logic             zero,
  output logic             ovf
`else
  output logic             zero
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [CntW-1:0]  count_q;
  logic [WIDTH-1:0] a_q, b_q, result_q, result_d;
  logic [1:0]       op_q;
  logic             carry_q, cout_q, zero_q;
  logic [WIDTH-1:0] a_sh, b_sh, bit_mask;
  logic             cell_x, cell_y, cell_out, cell_co, last_bit;
`ifdef BIT_SERIAL_ALU_OVF_EN
  logic             ovf_q;
`endif

  assign a_sh     = a_q >> count_q;
  assign b_sh     = b_q >> count_q;
  assign cell_x   = a_sh[0];
  // SUB is a + ~b + 1; the +1 comes from the carry preset at start.
  assign cell_y   = b_sh[0] ^ (op_q == OP_SUB);
  assign last_bit = (count_q == CntW'(WIDTH - 1));
  assign bit_mask = WIDTH'(1) << count_q;
  assign result_d = (result_q & ~bit_mask) | (cell_out ? bit_mask : '0);

  alu_cell_1b u_cell (
    .x   (cell_x),
    .y   (cell_y),
    .ci  (carry_q),
    .op  (op_q),
    .out (cell_out),
    .co  (cell_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (last_bit) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == S_SHIFT);
    done   = (state_q == S_DONE);
    result = result_q;
    cout   = cout_q;
    zero   = zero_q;
`ifdef BIT_SERIAL_ALU_OVF_EN
    ovf    = ovf_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      carry_q  <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
`ifdef BIT_SERIAL_ALU_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            op_q     <= op;
            carry_q  <= (op == OP_SUB);
            count_q  <= '0;
            result_q <= '0;
          end
        end
        S_SHIFT: begin
          result_q <= result_d;
          carry_q  <= cell_co;
          count_q  <= count_q + CntW'(1);
          if (last_bit) begin
            cout_q <= cell_co;
            zero_q <= (result_d == '0);
`ifdef BIT_SERIAL_ALU_OVF_EN
            // Signed overflow: carry into the MSB differs from carry out of it.
            ovf_q  <= is_arith(op_q) & (carry_q ^ cell_co);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_alu.sv
// Directed self-checking bench for bit_serial_alu (WIDTH = 8).
module tb_bit_serial_alu;
  import alu_defs::*;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, cout, zero;
  logic [W-1:0] result;
`ifdef BIT_SERIAL_ALU_OVF_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bit_serial_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
`ifdef BIT_SERIAL_ALU_OVF_EN
    .zero   (zero),
    .ovf    (ovf)
`else
    .zero   (zero)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a start pulse; returns #1 after the start edge.
  task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int lat);
    bit seen;
    seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) seen = 1'b1;
    end
    if (!seen) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_check(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W-1:0] exp_res,
                           input logic exp_cout, input logic exp_zero, input logic exp_ovf);
    int lat;
    start_op(o, x, y);
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(tag, lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'(W));
    check_eq({tag, "_res"}, 32'(result), 32'(exp_res));
    check_eq({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    check_eq({tag, "_zero"}, 32'(zero), 32'(exp_zero));
`ifdef BIT_SERIAL_ALU_OVF_EN
    check_eq({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) check_eq({tag, "_ovfx"}, 32'd0, 32'd1);
`endif
    @(posedge clk);
    #1;
    check_eq({tag, "_done_once"}, 32'(done), 32'd0);
    check_eq({tag, "_hold"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    int ndone;
    logic [W-1:0] res_at_done;

    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_res", 32'(result), 32'd0);
    check_eq("rst_cz", 32'({cout, zero}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_check("add", OP_ADD, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0, 1'b1);
    run_check("sub1", OP_SUB, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0, 1'b0);
    run_check("sub2", OP_SUB, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_check("nor", OP_NOR, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0);
    run_check("or", OP_OR, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0, 1'b0);
    run_check("ovf", OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1);

    // Start during SHIFT must be ignored.
    start_op(OP_ADD, 8'h01, 8'h01);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = 8'hFF;
    b = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    res_at_done = '0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        res_at_done = result;
      end
    end
    check_eq("ign_ndone", 32'(ndone), 32'd1);
    check_eq("ign_res", 32'(res_at_done), 32'h02);

    run_check("wrap", OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);

    // Abort mid-operation with reset; cout/zero are 1 from the previous op.
    start_op(OP_OR, 8'hFF, 8'h00);
    repeat (4) @(posedge clk);
    #1;
    check_eq("abort_busy_pre", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_res", 32'(result), 32'd0);
    check_eq("abort_cz", 32'({cout, zero}), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check_eq("abort_nodone", 32'(ndone), 32'd0);

    run_check("post", OP_ADD, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
